// File: rtl/rr_tdm_tx.sv
// rr_tdm_tx: two-channel round-robin TDM transmitter.
// Per-channel FIFOs feed one shared registered bus in strict alternating
// slots (slot 0 = channel 0, slot 1 = channel 1). Empty slots are sent as
// idles and counted per channel in saturating underrun counters.
module rr_tdm_tx #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [WIDTH-1:0]     din0,
   input  logic                 din0_valid,
   output logic                 din0_ready,
   input  logic [WIDTH-1:0]     din1,
   input  logic                 din1_valid,
   output logic                 din1_ready,
   output logic [WIDTH-1:0]     dout,
   output logic                 dout_valid,
   output logic                 dout_slot,
   output logic [CNT_WIDTH-1:0] underrun0,
   output logic [CNT_WIDTH-1:0] underrun1
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0]        FULL    = CW'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] mem0 [FIFO_DEPTH];
   logic [WIDTH-1:0] mem1 [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr0, rd_ptr0, wr_ptr1, rd_ptr1;
   logic [CW-1:0]    count0, count1;
   logic             slot;

   logic             push0, push1, pop0, pop1, empty0, empty1;
   logic             slot_nxt, dout_valid_nxt, dout_slot_nxt;
   logic [WIDTH-1:0] dout_nxt;
   logic [CNT_WIDTH-1:0] underrun0_nxt, underrun1_nxt;

   // Write-side handshake: ready depends only on fullness, never on a same-cycle pop
   assign din0_ready = rst & (count0 != FULL);
   assign din1_ready = rst & (count1 != FULL);
   assign push0      = din0_valid & din0_ready;
   assign push1      = din1_valid & din1_ready;
   assign empty0     = (count0 == '0);
   assign empty1     = (count1 == '0);

   // Slot scheduler, pop decision and next output word / underrun values
   always_comb begin
      slot_nxt       = 1'b0;
      pop0           = 1'b0;
      pop1           = 1'b0;
      dout_nxt       = dout;
      dout_valid_nxt = 1'b0;
      dout_slot_nxt  = 1'b0;
      underrun0_nxt  = underrun0;
      underrun1_nxt  = underrun1;
      if (enable) begin
         slot_nxt      = ~slot;
         dout_slot_nxt = slot;
         if (!slot) begin
            if (!empty0) begin
               pop0           = 1'b1;
               dout_nxt       = mem0[rd_ptr0];
               dout_valid_nxt = 1'b1;
            end else if (underrun0 != CNT_MAX) begin
               underrun0_nxt = underrun0 + CNT_WIDTH'(1);
            end
         end else begin
            if (!empty1) begin
               pop1           = 1'b1;
               dout_nxt       = mem1[rd_ptr1];
               dout_valid_nxt = 1'b1;
            end else if (underrun1 != CNT_MAX) begin
               underrun1_nxt = underrun1 + CNT_WIDTH'(1);
            end
         end
      end
   end

   // Output bus, slot phase and underrun counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot       <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_slot  <= 1'b0;
         underrun0  <= '0;
         underrun1  <= '0;
      end else begin
         slot       <= slot_nxt;
         dout       <= dout_nxt;
         dout_valid <= dout_valid_nxt;
         dout_slot  <= dout_slot_nxt;
         underrun0  <= underrun0_nxt;
         underrun1  <= underrun1_nxt;
      end
   end

   // Channel 0 FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr0 <= '0;
         rd_ptr0 <= '0;
         count0  <= '0;
      end else begin
         if (push0) wr_ptr0 <= wr_ptr0 + AW'(1);
         if (pop0)  rd_ptr0 <= rd_ptr0 + AW'(1);
         if (push0 && !pop0)      count0 <= count0 + CW'(1);
         else if (!push0 && pop0) count0 <= count0 - CW'(1);
      end
   end

   // Channel 1 FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr1 <= '0;
         rd_ptr1 <= '0;
         count1  <= '0;
      end else begin
         if (push1) wr_ptr1 <= wr_ptr1 + AW'(1);
         if (pop1)  rd_ptr1 <= rd_ptr1 + AW'(1);
         if (push1 && !pop1)      count1 <= count1 + CW'(1);
         else if (!push1 && pop1) count1 <= count1 - CW'(1);
      end
   end

   // FIFO storage; contents are only ever read behind a valid count, so no reset
   always_ff @(posedge clk) begin
      if (push0) mem0[wr_ptr0] <= din0;
      if (push1) mem1[wr_ptr1] <= din1;
   end

endmodule

// File: doc/rr_tdm_tx.md
# rr_tdm_tx

Two-channel round-robin TDM transmitter: the sending end of the alternating two-word time-division stream that the capture/round-robin receive path consumes. It buffers independent 8-bit streams from two sources in small per-channel FIFOs. It emits them on one shared bus in strict alternating slots (slot 0 = channel 0, slot 1 = channel 1), with a valid flag and slot tag. Empty slots go out as idles and are counted per channel as underruns.

## Interface
Parameters:
- WIDTH, 8, data word width per channel and on the output bus
- FIFO_DEPTH, 4, words per channel FIFO; power of two, ≥ 2
- CNT_WIDTH, 8, width of each saturating underrun counter

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset; deasserts synchronously with clk externally
- enable  in  1  slot scheduler run; low = bus idle, slot phase held
- din0  in  WIDTH  channel 0 write data
- din0_valid  in  1  channel 0 write request
- din0_ready  out  1  channel 0 FIFO can accept
- din1  in  WIDTH  channel 1 write data
- din1_valid  in  1  channel 1 write request
- din1_ready  out  1  channel 1 FIFO can accept
- dout  out  WIDTH  TDM output word, registered
- dout_valid  out  1  dout holds a real word, registered
- dout_slot  out  1  slot/channel tag of current dout, registered
- underrun0  out  CNT_WIDTH  channel 0 empty-slot count, saturating
- underrun1  out  CNT_WIDTH  channel 1 empty-slot count, saturating

## Operation
- Reset (rst=0, async): FIFOs emptied (pointers, counts = 0), slot = 0, dout = 0, dout_valid = 0, dout_slot = 0, underrun0/1 = 0, din0_ready = din1_ready = 0.
- Write side per channel k: dink_ready = rst & (count_k != FIFO_DEPTH). Push when dink_valid & dink_ready. Full-FIFO push is refused even if the same cycle pops: ready depends on full only, not on pop.
- Slot counter: 1-bit `slot`. While enable=1 it toggles every cycle. While enable=0 it is forced to 0, so the first enabled cycle is always slot 0.
- Per enabled cycle, serve channel k = slot:
  - FIFO k non-empty: pop head, next cycle dout = head, dout_valid = 1, dout_slot = k.
  - FIFO k empty: next cycle dout_valid = 0, dout holds previous value, dout_slot = k. underrun_k increments unless it equals 2^CNT_WIDTH−1 (saturate, no wrap).
- enable=0: no pops, no underrun counting, next cycle dout_valid = 0, dout_slot = 0, dout holds.
- Simultaneous push and pop on the same FIFO: both occur; count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH, width clog2(FIFO_DEPTH)+1.
- Reset mid-operation: all buffered words are discarded, outputs go to reset values immediately (async). No partial word is ever presented.

## Timing
- FIFO has no fall-through. A word pushed in cycle N is poppable from cycle N+1.
- Pop-to-output latency: 1 cycle, so push-to-dout is at least 2 cycles, more if the slot does not match.
- Output rate: at most one word per channel every 2 cycles. Aggregate is one word per cycle when both FIFOs are kept non-empty.
- dout_slot strictly alternates 0,1,0,1… from the second enabled cycle onward, independent of data availability. Receivers may rely on phase alone.
- Underrun counters update in the same edge that registers the idle slot, so they are visible together with the corresponding dout_valid=0.
- Ready deasserts in the cycle the count reaches FIFO_DEPTH. It reasserts the cycle after a pop takes the count below FIFO_DEPTH.

## Test plan
- Reset/idle: hold rst=0 with random inputs -> all outputs 0, readies 0. Release with enable=0 -> readies 1, dout_valid stays 0, underruns stay 0.
- Interleave: preload ch0 = 0x11,0x12 and ch1 = 0xA1,0xA2, then enable -> dout = 0x11,0xA1,0x12,0xA2 with slots 0,1,0,1 and valid 1 on 4 consecutive cycles starting 1 cycle after enable. Then valid 0 with underrun0 and underrun1 incrementing alternately.
- Backpressure: enable=0, push 5 words into ch0 (DEPTH 4) -> 4 accepted, din0_ready low after the 4th. Enable -> ready returns high the cycle after the first slot-0 pop, and the 5th word is then accepted.
- One-sided traffic: only ch1 fed continuously -> dout_valid pattern 0,1,0,1; underrun0 increments every other cycle, underrun1 stays 0.
- Saturation: CNT_WIDTH=2, ch0 empty for 10 slot-0 periods -> underrun0 stops at 3.
- Async reset mid-burst: assert rst between edges with both FIFOs half full -> outputs zero immediately. After release the old data is never emitted and the first enabled slot is 0.
